// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: core (C) vs debug/loader (D).
// Round-robin grant, debug lock, read data returned one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  input  logic [1:0]            c_size,
  output logic                  c_gnt,
  output logic                  c_stall,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_size,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [1:0]            mem_size,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  owner_e                last_owner;
  owner_e                rsp_owner;
  logic                  rsp_valid;
  logic                  rd_gnt;
  logic [DATA_WIDTH-1:0] c_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  // Grant decode; arms are mutually exclusive so the case stays unique.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        d_lock: begin
          d_gnt = d_req;
        end
        !d_lock && c_req && d_req: begin
          if (last_owner == OWN_D) begin
            c_gnt = 1'b1;
          end else begin
            d_gnt = 1'b1;
          end
        end
        !d_lock && c_req && !d_req: begin
          c_gnt = 1'b1;
        end
        !d_lock && !c_req && d_req: begin
          d_gnt = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign c_stall = c_req & ~c_gnt;

  // Memory port mux; C's fields sit on the bus whenever D is not granted.
  always_comb begin
    mem_addr  = c_addr;
    mem_wdata = c_wdata;
    mem_size  = c_size;
    mem_we    = c_gnt & c_we;
    mem_re    = c_gnt & ~c_we;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_size  = d_size;
      mem_we    = d_we;
      mem_re    = ~d_we;
    end
  end

  assign rd_gnt = (c_gnt & ~c_we) | (d_gnt & ~d_we);

  // Round-robin history and read-response tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_D;
      rsp_valid  <= 1'b0;
      rsp_owner  <= OWN_C;
    end else begin
      if (c_gnt) begin
        last_owner <= OWN_C;
      end else if (d_gnt) begin
        last_owner <= OWN_D;
      end
      rsp_valid <= rd_gnt;
      if (rd_gnt) begin
        if (d_gnt) begin
          rsp_owner <= OWN_D;
        end else begin
          rsp_owner <= OWN_C;
        end
      end
    end
  end

  assign c_rvalid = rsp_valid & (rsp_owner == OWN_C);
  assign d_rvalid = rsp_valid & (rsp_owner == OWN_D);

  // Capture returned data so each port keeps its last read value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (c_rvalid) begin
        c_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory data arrives in the rvalid cycle, so pass it straight through
  // then and show the captured copy otherwise.
  assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural
// single-port memory returning data the cycle after mem_re.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req;
  logic        c_we;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_size;
  logic        c_gnt;
  logic        c_stall;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  typedef struct {
    bit          v;
    bit          own_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_c;
  logic [31:0] last_d;
  int          n_cmp;
  int          n_err;

  dmem_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_size   (c_size),
    .c_gnt    (c_gnt),
    .c_stall  (c_stall),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_size   (d_size),
    .d_lock   (d_lock),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_size (mem_size),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit cr, input bit cw,
                      input logic [7:0] ca, input logic [31:0] cwd,
                      input bit dr, input bit dw,
                      input logic [7:0] da, input logic [31:0] dwd,
                      input bit lk, input bit ecg, input bit edg);
    rsp_t e;
    rsp_t n;
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cwd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    d_lock = lk;
    #3;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{v: 1'b0, own_d: 1'b0, data: 32'h0};
    if (e.v && !e.own_d) last_c = e.data;
    if (e.v && e.own_d) last_d = e.data;
    chk("c_rvalid", {31'b0, c_rvalid}, {31'b0, e.v && !e.own_d});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e.v && e.own_d});
    chk("c_rdata", c_rdata, last_c);
    chk("d_rdata", d_rdata, last_d);
    chk("c_gnt", {31'b0, c_gnt}, {31'b0, ecg});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    chk("c_stall", {31'b0, c_stall}, {31'b0, cr && !ecg});
    chk("mem_re", {31'b0, mem_re},
        {31'b0, (ecg && !cw) || (edg && !dw)});
    chk("mem_we", {31'b0, mem_we},
        {31'b0, (ecg && cw) || (edg && dw)});
    chk("mem_addr", {24'b0, mem_addr}, {24'b0, edg ? da : ca});
    chk("mem_size", {30'b0, mem_size}, {30'b0, edg ? 2'b11 : 2'b00});
    if (ecg && cw) begin
      chk("mem_wdata", mem_wdata, cwd);
      ref_mem[ca] = cwd;
    end
    if (edg && dw) begin
      chk("mem_wdata", mem_wdata, dwd);
      ref_mem[da] = dwd;
    end
    n = '{v: 1'b0, own_d: 1'b0, data: 32'h0};
    if (ecg && !cw) n = '{v: 1'b1, own_d: 1'b0, data: ref_mem[ca]};
    if (edg && !dw) n = '{v: 1'b1, own_d: 1'b1, data: ref_mem[da]};
    sb.push_back(n);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0;
    d_req = 1'b1; d_we = 1'b0;
    d_lock = 1'b0;
    #1;
    chk("rst c_rvalid", {31'b0, c_rvalid}, 32'h0);
    chk("rst d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst c_rdata", c_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    chk("rst c_gnt", {31'b0, c_gnt}, 32'h0);
    chk("rst d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst mem_re", {31'b0, mem_re}, 32'h0);
    sb.delete();
    last_c = 32'h0;
    last_d = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_size = 2'b00;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 2'b11;
    d_lock = 0;
    mem_rdata = 32'h0;
    last_c = 32'h0;
    last_d = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA5000000 | (i * 32'h00010101);
    end
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h04] = 32'hC0DE0004;
    mem[8'h08] = 32'hD00D0008;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    #2;
    do_reset();

    // core-only read
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0, 1, 0);
    idle();
    idle();

    // persistent contention after reset: C, D, C, D
    do_reset();
    step(1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 1, 0);
    step(1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 0, 1);
    step(1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 1, 0);
    step(1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 0, 1);
    idle();

    // debug lock for three cycles, then C wins
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h10, 32'h0, 1, 0, 8'h08, 32'h0, 1, 0, 1);
    end
    step(1, 0, 8'h10, 32'h0, 1, 0, 8'h08, 32'h0, 0, 1, 0);
    idle();

    // debug write then read-back
    step(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'h12345678, 0, 0, 1);
    step(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 0, 1);
    idle();

    // core write, then back-to-back C and D reads
    step(1, 1, 8'h30, 32'hCAFEF00D, 0, 0, 8'h00, 32'h0, 0, 1, 0);
    step(1, 0, 8'h04, 32'h0, 0, 0, 8'h00, 32'h0, 0, 1, 0);
    step(0, 0, 8'h00, 32'h0, 1, 0, 8'h08, 32'h0, 0, 0, 1);
    step(1, 0, 8'h30, 32'h0, 0, 0, 8'h00, 32'h0, 0, 1, 0);
    idle();
    idle();

    // reset right after a core read grant
    step(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0, 1, 0);
    do_reset();
    idle();
    step(1, 0, 8'h04, 32'h0, 1, 0, 8'h08, 32'h0, 0, 1, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
